// File: rtl/reg_bank_pkg.sv
// Shared constants for the parametrised register bank, its decoder and hazard unit.
package reg_bank_pkg;

   localparam int DATA_W_DEF = 8;
   localparam int ADDR_W_DEF = 3;

   function automatic int depth_of(input int addr_w);
      return 1 << addr_w;
   endfunction

endpackage

// File: rtl/reg_bank_scoreboard.sv
// Per-register busy bits: marks claim a destination, writes retire it.
module reg_bank_scoreboard
   import reg_bank_pkg::*;
#(
   parameter int ADDR_W   = ADDR_W_DEF,
   parameter int ZERO_REG = 1,
   parameter int BYPASS   = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              reg_write,
   input  logic [ADDR_W-1:0] write_reg,
   input  logic              mark_busy,
   input  logic [ADDR_W-1:0] mark_reg,
   input  logic [ADDR_W-1:0] read_reg1,
   input  logic [ADDR_W-1:0] read_reg2,
   output logic              busy1,
   output logic              busy2
);

   localparam int DEPTH = depth_of(ADDR_W);

   logic [DEPTH-1:0] busy_q, busy_d;
   logic             mark_ok;

   assign mark_ok = mark_busy && !((ZERO_REG != 0) && (mark_reg == '0));

   // Clear first, then set: a new producer claiming the register wins.
   always_comb begin
      busy_d = busy_q;
      if (reg_write) busy_d[write_reg] = 1'b0;
      if (mark_ok)   busy_d[mark_reg]  = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) busy_q <= '0;
      else     busy_q <= busy_d;
   end

   function automatic logic lookup(input logic [DEPTH-1:0] bv,
                                   input logic [ADDR_W-1:0] idx,
                                   input logic              we,
                                   input logic [ADDR_W-1:0] wa,
                                   input logic              mb,
                                   input logic [ADDR_W-1:0] ma);
      if ((ZERO_REG != 0) && (idx == '0))                 return 1'b0;
      if ((BYPASS != 0) && we && (wa == idx) && !(mb && (ma == idx))) return 1'b0;
      return bv[idx];
   endfunction

   always_comb begin
      busy1 = lookup(busy_q, read_reg1, reg_write, write_reg, mark_busy, mark_reg);
      busy2 = lookup(busy_q, read_reg2, reg_write, write_reg, mark_busy, mark_reg);
   end

endmodule

// File: rtl/reg_bank_param.sv
// Parametrised register bank: 2 async read ports, 1 sync write port,
// optional zero register and write-to-read bypass, plus busy scoreboard.
module reg_bank_param
   import reg_bank_pkg::*;
#(
   parameter int DATA_W   = DATA_W_DEF,
   parameter int ADDR_W   = ADDR_W_DEF,
   parameter int ZERO_REG = 1,
   parameter int BYPASS   = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              reg_write,
   input  logic [ADDR_W-1:0] write_reg,
   input  logic [DATA_W-1:0] write_data,
   input  logic [ADDR_W-1:0] read_reg1,
   input  logic [ADDR_W-1:0] read_reg2,
   output logic [DATA_W-1:0] read_data1,
   output logic [DATA_W-1:0] read_data2,
   input  logic              mark_busy,
   input  logic [ADDR_W-1:0] mark_reg,
   output logic              busy1,
   output logic              busy2
);

   localparam int DEPTH = depth_of(ADDR_W);

   logic [DEPTH-1:0][DATA_W-1:0] regs_q, regs_d;
   logic                         wr_ok;

   // Writes to a hardwired zero register are dropped entirely, including bypass.
   assign wr_ok = reg_write && !((ZERO_REG != 0) && (write_reg == '0));

   always_comb begin
      regs_d = regs_q;
      if (wr_ok) regs_d[write_reg] = write_data;
   end

   always_ff @(posedge clk) begin
      if (rst) regs_q <= '0;
      else     regs_q <= regs_d;
   end

   function automatic logic [DATA_W-1:0] rd(input logic [DEPTH-1:0][DATA_W-1:0] rv,
                                            input logic [ADDR_W-1:0]             idx,
                                            input logic                          we,
                                            input logic [ADDR_W-1:0]             wa,
                                            input logic [DATA_W-1:0]             wd);
      if ((ZERO_REG != 0) && (idx == '0))    return '0;
      if ((BYPASS != 0) && we && (wa == idx)) return wd;
      return rv[idx];
   endfunction

   always_comb begin
      read_data1 = rd(regs_q, read_reg1, wr_ok, write_reg, write_data);
      read_data2 = rd(regs_q, read_reg2, wr_ok, write_reg, write_data);
   end

   reg_bank_scoreboard #(
      .ADDR_W   (ADDR_W),
      .ZERO_REG (ZERO_REG),
      .BYPASS   (BYPASS)
   ) u_sb (
      .clk       (clk),
      .rst       (rst),
      .reg_write (reg_write),
      .write_reg (write_reg),
      .mark_busy (mark_busy),
      .mark_reg  (mark_reg),
      .read_reg1 (read_reg1),
      .read_reg2 (read_reg2),
      .busy1     (busy1),
      .busy2     (busy2)
   );

endmodule

// File: tb/tb_reg_bank_param.sv
// Scoreboard bench: three bank configurations share one stimulus stream and
// are checked against an array-based reference model.
module tb_reg_bank_param;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst, reg_write, mark_busy;
   logic [3:0]  write_reg, read_reg1, read_reg2, mark_reg;
   logic [15:0] write_data;

   // cfg0: 8/3 zero+bypass, cfg1: 8/3 zero no bypass, cfg2: 16/4 no zero, bypass
   logic [7:0]  a_rd1, a_rd2, b_rd1, b_rd2;
   logic [15:0] c_rd1, c_rd2;
   logic        a_b1, a_b2, b_b1, b_b2, c_b1, c_b2;

   reg_bank_param #(.DATA_W(8), .ADDR_W(3), .ZERO_REG(1), .BYPASS(1)) u_a (
      .clk(clk), .rst(rst), .reg_write(reg_write), .write_reg(write_reg[2:0]),
      .write_data(write_data[7:0]), .read_reg1(read_reg1[2:0]), .read_reg2(read_reg2[2:0]),
      .read_data1(a_rd1), .read_data2(a_rd2), .mark_busy(mark_busy),
      .mark_reg(mark_reg[2:0]), .busy1(a_b1), .busy2(a_b2));

   reg_bank_param #(.DATA_W(8), .ADDR_W(3), .ZERO_REG(1), .BYPASS(0)) u_b (
      .clk(clk), .rst(rst), .reg_write(reg_write), .write_reg(write_reg[2:0]),
      .write_data(write_data[7:0]), .read_reg1(read_reg1[2:0]), .read_reg2(read_reg2[2:0]),
      .read_data1(b_rd1), .read_data2(b_rd2), .mark_busy(mark_busy),
      .mark_reg(mark_reg[2:0]), .busy1(b_b1), .busy2(b_b2));

   reg_bank_param #(.DATA_W(16), .ADDR_W(4), .ZERO_REG(0), .BYPASS(1)) u_c (
      .clk(clk), .rst(rst), .reg_write(reg_write), .write_reg(write_reg),
      .write_data(write_data), .read_reg1(read_reg1), .read_reg2(read_reg2),
      .read_data1(c_rd1), .read_data2(c_rd2), .mark_busy(mark_busy),
      .mark_reg(mark_reg), .busy1(c_b1), .busy2(c_b2));

   typedef struct packed {
      logic            chk;
      logic [2:0][15:0] d1;
      logic [2:0][15:0] d2;
      logic [2:0]       b1;
      logic [2:0]       b2;
   } exp_t;

   exp_t q[$];
   int   n_tests = 0;
   int   n_fail  = 0;

   int   awv[3] = '{3, 3, 4};
   int   dwv[3] = '{8, 8, 16};
   bit   zr[3]  = '{1'b1, 1'b1, 1'b0};
   bit   bp[3]  = '{1'b1, 1'b0, 1'b1};

   logic [15:0] mreg[3][16];
   bit          mbusy[3][16];

   function automatic logic [3:0] am(int c);
      return (awv[c] == 4) ? 4'hF : 4'h7;
   endfunction

   function automatic logic [15:0] dm(int c);
      return (dwv[c] == 16) ? 16'hFFFF : 16'h00FF;
   endfunction

   function automatic logic [15:0] m_read(int c, logic [3:0] idx);
      logic [3:0] i, w;
      i = idx & am(c);
      w = write_reg & am(c);
      if (zr[c] && i == 0) return 16'h0;
      if (bp[c] && reg_write && w == i && !(zr[c] && w == 0)) return write_data & dm(c);
      return mreg[c][i];
   endfunction

   function automatic logic m_busy(int c, logic [3:0] idx);
      logic [3:0] i, w, m;
      i = idx & am(c);
      w = write_reg & am(c);
      m = mark_reg & am(c);
      if (zr[c] && i == 0) return 1'b0;
      if (bp[c] && reg_write && w == i && !(mark_busy && m == i)) return 1'b0;
      return mbusy[c][i];
   endfunction

   task automatic step(input logic r, input logic we, input logic [3:0] wa,
                       input logic [15:0] wd, input logic [3:0] r1, input logic [3:0] r2,
                       input logic mb, input logic [3:0] ma);
      exp_t e;
      logic [3:0] w, m;
      rst = r; reg_write = we; write_reg = wa; write_data = wd;
      read_reg1 = r1; read_reg2 = r2; mark_busy = mb; mark_reg = ma;
      e.chk = !r;
      for (int c = 0; c < 3; c++) begin
         e.d1[c] = m_read(c, r1);
         e.d2[c] = m_read(c, r2);
         e.b1[c] = m_busy(c, r1);
         e.b2[c] = m_busy(c, r2);
      end
      q.push_back(e);
      @(posedge clk);
      for (int c = 0; c < 3; c++) begin
         if (r) begin
            for (int i = 0; i < 16; i++) begin
               mreg[c][i]  = 16'h0;
               mbusy[c][i] = 1'b0;
            end
         end else begin
            w = wa & am(c);
            m = ma & am(c);
            if (we && !(zr[c] && w == 0)) mreg[c][w] = wd & dm(c);
            if (we) mbusy[c][w] = 1'b0;
            if (mb && !(zr[c] && m == 0)) mbusy[c][m] = 1'b1;
         end
      end
      #1;
   endtask

   task automatic cmp(input string name, input logic [15:0] got, input logic [15:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got %h expected %h at %0t", name, got, exp, $time);
      end
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clk);
         if (q.size() > 0) begin
            e = q.pop_front();
            if (e.chk) begin
               cmp("cfg0 rd1",  {8'h0, a_rd1}, e.d1[0]);
               cmp("cfg0 rd2",  {8'h0, a_rd2}, e.d2[0]);
               cmp("cfg0 busy1", {15'h0, a_b1}, {15'h0, e.b1[0]});
               cmp("cfg0 busy2", {15'h0, a_b2}, {15'h0, e.b2[0]});
               cmp("cfg1 rd1",  {8'h0, b_rd1}, e.d1[1]);
               cmp("cfg1 rd2",  {8'h0, b_rd2}, e.d2[1]);
               cmp("cfg1 busy1", {15'h0, b_b1}, {15'h0, e.b1[1]});
               cmp("cfg1 busy2", {15'h0, b_b2}, {15'h0, e.b2[1]});
               cmp("cfg2 rd1",  c_rd1, e.d1[2]);
               cmp("cfg2 rd2",  c_rd2, e.d2[2]);
               cmp("cfg2 busy1", {15'h0, c_b1}, {15'h0, e.b1[2]});
               cmp("cfg2 busy2", {15'h0, c_b2}, {15'h0, e.b2[2]});
            end
         end
      end
   end

   initial begin : driver
      logic [3:0] wa, r1, r2;
      rst = 1'b1; reg_write = 1'b0; write_reg = '0; write_data = '0;
      read_reg1 = '0; read_reg2 = '0; mark_busy = 1'b0; mark_reg = '0;
      for (int c = 0; c < 3; c++)
         for (int i = 0; i < 16; i++) begin
            mreg[c][i] = 16'h0; mbusy[c][i] = 1'b0;
         end
      @(posedge clk); #1;
      step(1, 0, 0, 0, 0, 0, 0, 0);
      // post-reset sweep of every index on both ports
      for (int i = 0; i < 16; i++) step(0, 0, 0, 0, 4'(i), 4'(15 - i), 0, 0);
      // same-cycle write and read of r3
      step(0, 1, 3, 16'h00A5, 3, 3, 0, 0);
      step(0, 0, 0, 0, 3, 3, 0, 0);
      // writes and marks to r0
      step(0, 1, 0, 16'h00FF, 0, 0, 1, 0);
      step(0, 0, 0, 0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0, 0, 0, 0);
      // scoreboard on r5
      step(0, 0, 0, 0, 5, 5, 1, 5);
      step(0, 0, 0, 0, 5, 5, 0, 0);
      step(0, 1, 5, 16'h003C, 5, 5, 0, 0);
      step(0, 0, 0, 0, 5, 5, 0, 0);
      step(0, 1, 5, 16'h0077, 5, 5, 1, 5);
      step(0, 0, 0, 0, 5, 5, 0, 0);
      // reset beats a concurrent write and mark
      step(0, 0, 0, 0, 2, 6, 1, 6);
      step(1, 1, 2, 16'h0011, 2, 6, 1, 6);
      step(0, 0, 0, 0, 2, 6, 0, 0);
      step(0, 1, 2, 16'h0022, 1, 6, 0, 0);
      step(0, 0, 0, 0, 2, 2, 0, 0);
      // top index of the wide configuration
      step(0, 1, 15, 16'hBEEF, 0, 15, 0, 0);
      step(0, 0, 0, 0, 7, 15, 0, 0);
      // random traffic
      for (int n = 0; n < 10000; n++) begin
         wa = 4'($urandom_range(0, 15));
         r1 = ($urandom_range(0, 3) == 0) ? wa : 4'($urandom_range(0, 15));
         r2 = ($urandom_range(0, 3) == 0) ? wa : 4'($urandom_range(0, 15));
         step(($urandom_range(0, 199) == 0), ($urandom_range(0, 1) == 1), wa,
              16'($urandom), r1, r2, ($urandom_range(0, 2) == 0),
              ($urandom_range(0, 3) == 0) ? wa : 4'($urandom_range(0, 15)));
      end
      @(negedge clk);
      @(negedge clk);
      n_tests++;
      if (q.size() != 0) begin
         n_fail++;
         $display("FAIL drain %0d expectations left, expected 0", q.size());
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/reg_bank_param.md
Name: reg_bank_param

Overview:
- Parametrised successor to the 8x8 single-cycle register bank.
- Configurable data width and depth; two async read ports and one sync write port, as before.
- Adds synchronous reset of all registers, an optional hardwired zero register, and an optional write-to-read bypass.
- Adds a per-register busy scoreboard so multi-cycle producers can mark a destination pending. The datapath uses it for stall/hazard detection.

Parameters:
- DATA_W, 8, register width in bits.
- ADDR_W, 3, register index width; DEPTH = 2**ADDR_W registers.
- ZERO_REG, 1, 1 = register 0 always reads 0, ignores writes and is never busy.
- BYPASS, 1, 1 = a same-cycle write is forwarded to matching read ports.

Ports:
- clk, input, 1, system clock; all state updates on the rising edge.
- rst, input, 1, synchronous active-high reset.
- reg_write, input, 1, write enable.
- write_reg, input, ADDR_W, write index.
- write_data, input, DATA_W, write data.
- read_reg1, input, ADDR_W, read port 1 index.
- read_reg2, input, ADDR_W, read port 2 index.
- read_data1, output, DATA_W, read port 1 data (combinational).
- read_data2, output, DATA_W, read port 2 data (combinational).
- mark_busy, input, 1, request to set the busy bit of mark_reg.
- mark_reg, input, ADDR_W, register being claimed by a pending producer.
- busy1, output, 1, register at read_reg1 is pending.
- busy2, output, 1, register at read_reg2 is pending.

Behaviour:
- One clock domain (clk). Reset is synchronous and active-high (rst); rst sampled high on a rising edge clears all DEPTH registers to 0 and all busy bits to 0.
- Reset has priority over reg_write and mark_busy in the same cycle. Once rst is seen, read_data1/2 = 0 and busy1/2 = 0 for any index until the next write or mark.
- Reset mid-operation discards in-flight marks and the current write.
- Write: on a rising edge with reg_write=1 and rst=0, regs[write_reg] <= write_data, visible through the array from the next cycle.
- ZERO_REG=1: writes with write_reg=0 are dropped.
- Read (combinational, zero latency):
  - ZERO_REG=1 and index 0 -> 0.
  - Otherwise, BYPASS=1 and reg_write=1 and write_reg==read_regN (and not a dropped zero write) -> write_data.
  - Otherwise -> regs[read_regN].
  - Both ports may address the same register; both return the same value.
- BYPASS=0: reads return the pre-edge value; a write is visible only from the next cycle.
- Scoreboard: DEPTH busy bits, updated on the rising edge.
  - reg_write=1 clears busy[write_reg].
  - mark_busy=1 sets busy[mark_reg].
  - Same edge, same index: set wins (a new producer claims the register after the old one retires).
  - Same edge, different indices: both take effect.
  - Marking an already-busy register leaves it busy. Writing a non-busy register leaves it clear.
  - ZERO_REG=1: a mark of index 0 is ignored.
- busyN = busy[read_regN], except:
  - forced 0 when BYPASS=1 and reg_write=1 and write_reg==read_regN and not (mark_busy=1 and mark_reg==read_regN);
  - forced 0 for index 0 when ZERO_REG=1.
- Width rules: no arithmetic. Indices are always in range since DEPTH = 2**ADDR_W, so there is no out-of-range case.
- No X may propagate from an unwritten register: all registers are defined after the first reset.

Decomposition:
- Shared package reg_bank_pkg holds the default DATA_W/ADDR_W constants and the DEPTH derivation, shared with the decoder and hazard unit.
- One natural sub-module: reg_bank_scoreboard (busy vector, set/clear priority, busy1/busy2 lookup with bypass-clear). The data array and read muxing stay in the top module.

Test Plan:
- Reset, then read all 8 indices on both ports -> read_data1/2 = 0x00 and busy1/2 = 0 for every index.
- Write 0xA5 to r3 with read_reg1=3, read_reg2=3 in the same cycle:
  - BYPASS=1 -> both ports show 0xA5 that cycle.
  - BYPASS=0 -> both show 0x00, then 0xA5 the next cycle.
- ZERO_REG=1: write 0xFF to r0 and mark r0 -> read r0 = 0x00 and busy = 0 on both ports on following cycles.
- mark r5, then read r5 -> busy1 = 1; write 0x3C to r5 -> busy1 = 0 that cycle (BYPASS=1) and 0x3C read; mark r5 and write r5 on the same edge -> busy remains 1 afterwards.
- Write r2 = 0x11 and mark r6 in the same cycle as rst=1 -> after the edge r2 = 0x00 and r6 not busy; write r2 = 0x22 next cycle -> 0x22 read back.
- Parameter sweep DATA_W=16, ADDR_W=4: write 0xBEEF to r15, read via port 2 -> 0xBEEF; random write/read/mark traffic compared against a reference model for 10k cycles.
